// File: rtl/pool_pkg.sv
// Shared constants, FSM state type and signed max helper for the 2x2 max-pool stage.
package pool_pkg;

  localparam int DATA_W  = 32;
  localparam int IN_DIM  = 28;
  localparam int OUT_DIM = IN_DIM / 2;
  localparam int COORD_W = 5;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/conv_maxpool_2x2_if.sv
// Sample stream into the pooling stage and pooled stream out of it.
// master drives the conv2 results; slave is the pooling block.
interface conv_maxpool_2x2_if #(
  parameter int DATA_W  = pool_pkg::DATA_W,
  parameter int COORD_W = pool_pkg::COORD_W
);

  logic                      in_valid;
  logic [COORD_W-1:0]        in_row;
  logic [COORD_W-1:0]        in_col;
  logic signed [DATA_W-1:0]  in_data;

  logic                      out_valid;
  logic [COORD_W-2:0]        out_row;
  logic [COORD_W-2:0]        out_col;
  logic signed [DATA_W-1:0]  out_data;
  logic                      frame_done;
  logic                      seq_err;

  modport master (
    output in_valid, in_row, in_col, in_data,
    input  out_valid, out_row, out_col, out_data, frame_done, seq_err
  );

  modport slave (
    input  in_valid, in_row, in_col, in_data,
    output out_valid, out_row, out_col, out_data, frame_done, seq_err
  );

endinterface

// File: rtl/pool_line_buffer.sv
// Half-width line buffer holding the even-row pair maxima of the current row pair.
// One synchronous write port, one combinational read port.
module pool_line_buffer
  import pool_pkg::*;
#(
  parameter int DEPTH = OUT_DIM,
  parameter int WIDTH = DATA_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: no reset on the storage array; every entry is written on the even row
  // before the odd row reads it, so reset would only cost flops and fanout.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv_maxpool_2x2.sv
// 2x2 stride-2 max pool over a raster-ordered conv2 result stream, with order checking.
// Define MAXPOOL_RELU_EN to clamp negative inputs to zero before pooling.
module conv_maxpool_2x2 #(
  parameter int DATA_W  = pool_pkg::DATA_W,
  parameter int IN_DIM  = pool_pkg::IN_DIM,
  parameter int COORD_W = pool_pkg::COORD_W
) (
  input  logic             clk,
  input  logic             rst,
  conv_maxpool_2x2_if.slave bus
);

  import pool_pkg::*;

  localparam logic [COORD_W-1:0] LAST = COORD_W'(IN_DIM - 1);

  typedef logic signed [DATA_W-1:0] sample_t;

  state_t               state, state_nx;
  logic [COORD_W-1:0]   exp_row, exp_col, exp_row_nx, exp_col_nx;
  logic                 accept, order_err;
  logic                 is_origin, is_last, in_range;
  logic                 lb_we, emit;
  sample_t              sample, h, lb_rdata, pair_max, pool_max;

  logic                 out_valid_q, frame_done_q, seq_err_q;
  logic [COORD_W-2:0]   out_row_q, out_col_q;
  sample_t              out_data_q;

`ifdef MAXPOOL_RELU_EN
  assign sample = bus.in_data[DATA_W-1] ? '0 : bus.in_data;
`else
  assign sample = bus.in_data;
`endif

  assign is_origin = (bus.in_row == '0) && (bus.in_col == '0);
  assign is_last   = (bus.in_row == LAST) && (bus.in_col == LAST);
  assign in_range  = (bus.in_row <= LAST) && (bus.in_col <= LAST);

  // NOTE: every always_comb output gets its default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    state_nx   = state;
    exp_row_nx = exp_row;
    exp_col_nx = exp_col;
    accept     = 1'b0;
    order_err  = 1'b0;
    if (bus.in_valid) begin
      unique case (state)
        IDLE: begin
          accept    = is_origin;
          order_err = !is_origin;
        end
        RUN: begin
          // A misordered sample is still pooled at its own coordinates; a fresh
          // (0,0) therefore restarts the frame.
          accept    = in_range;
          order_err = !in_range || (bus.in_row != exp_row) || (bus.in_col != exp_col);
        end
      endcase
      if (accept) begin
        if (is_last) begin
          state_nx   = IDLE;
          exp_row_nx = '0;
          exp_col_nx = '0;
        end else begin
          state_nx = RUN;
          if (bus.in_col == LAST) begin
            exp_row_nx = bus.in_row + 1'b1;
            exp_col_nx = '0;
          end else begin
            exp_row_nx = bus.in_row;
            exp_col_nx = bus.in_col + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      exp_row <= '0;
      exp_col <= '0;
    end else begin
      state   <= state_nx;
      exp_row <= exp_row_nx;
      exp_col <= exp_col_nx;
    end
  end

  assign lb_we    = accept && bus.in_col[0] && !bus.in_row[0];
  assign emit     = accept && bus.in_col[0] && bus.in_row[0];
  assign pair_max = smax(h, sample);
  assign pool_max = smax(lb_rdata, pair_max);

  pool_line_buffer #(
    .DEPTH (IN_DIM / 2),
    .WIDTH (DATA_W),
    .AW    (COORD_W - 1)
  ) u_line_buffer (
    .clk   (clk),
    .we    (lb_we),
    .waddr (bus.in_col[COORD_W-1:1]),
    .wdata (pair_max),
    .raddr (bus.in_col[COORD_W-1:1]),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h            <= '0;
      out_valid_q  <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      out_valid_q  <= emit;
      frame_done_q <= emit && is_last;
      if (accept && !bus.in_col[0]) h <= sample;
      if (emit) begin
        out_row_q  <= bus.in_row[COORD_W-1:1];
        out_col_q  <= bus.in_col[COORD_W-1:1];
        out_data_q <= pool_max;
      end
      if (order_err) seq_err_q <= 1'b1;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;
  assign bus.out_data   = out_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.seq_err    = seq_err_q;

endmodule

// File: tb/tb_conv_maxpool_2x2.sv
// Randomized bench for conv_maxpool_2x2: frames are stored as 2-D arrays and pooled
// windows are computed directly from them; follows MAXPOOL_RELU_EN like the design.
module tb_conv_maxpool_2x2;

  localparam int N  = 28;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv_maxpool_2x2_if bus ();

  conv_maxpool_2x2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic signed [DW-1:0] frm [N][N];

  bit                   pend_v, pend_fd, pend_chk, exp_err, win_test;
  int                   pend_r, pend_c;
  logic signed [DW-1:0] pend_d;
  int                   raster_idx;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] v);
`ifdef MAXPOOL_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic signed [DW-1:0] window_max(input int pr, input int pc);
    logic signed [DW-1:0] m;
    m = relu(frm[2*pr][2*pc]);
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (relu(frm[2*pr+dr][2*pc+dc]) > m) m = relu(frm[2*pr+dr][2*pc+dc]);
    return m;
  endfunction

  task automatic check_outputs();
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, pend_v});
    check("frame_done", {31'd0, bus.frame_done}, {31'd0, pend_fd});
    check("seq_err", {31'd0, bus.seq_err}, {31'd0, exp_err});
    if (pend_v) begin
      check("out_row", {28'd0, bus.out_row}, pend_r);
      check("out_col", {28'd0, bus.out_col}, pend_c);
      if (pend_chk) check("out_data", bus.out_data, pend_d);
      if (win_test && pend_r == 0 && pend_c == 0) check("win00_data", bus.out_data, 32'sd9);
    end
  endtask

  // Checks the outputs caused by the previous cycle, then presents one cycle of input.
  task automatic drive(input bit v, input int r, input int c, input bit chk);
    @(negedge clk);
    check_outputs();
    bus.in_valid = v;
    bus.in_row   = 5'(r);
    bus.in_col   = 5'(c);
    bus.in_data  = v ? frm[r][c] : $urandom();
    pend_v   = v && (r % 2 == 1) && (c % 2 == 1);
    pend_fd  = v && (r == N-1) && (c == N-1);
    pend_r   = r / 2;
    pend_c   = c / 2;
    pend_chk = chk;
    if (pend_v) pend_d = window_max(r / 2, c / 2);
    if (v) begin
      if (r * N + c != raster_idx) exp_err = 1'b1;
      raster_idx = (r * N + c + 1) % (N * N);
    end
  endtask

  task automatic run_frame(input int max_gap, input int skip_idx, input int stop_idx);
    for (int i = 0; i < N * N; i++) begin
      int  r, c, gap;
      bit  chk;
      if (i == stop_idx) return;
      if (i == skip_idx) continue;
      r   = i / N;
      c   = i % N;
      chk = !(skip_idx >= 0 && r / 2 == (skip_idx / N) / 2 && c / 2 == (skip_idx % N) / 2);
      drive(1'b1, r, c, chk);
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) drive(1'b0, 0, 0, 1'b1);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    check_outputs();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_row", {28'd0, bus.out_row}, 32'd0);
    check("rst_out_col", {28'd0, bus.out_col}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
    check("rst_seq_err", {31'd0, bus.seq_err}, 32'd0);
    pend_v     = 1'b0;
    pend_fd    = 1'b0;
    exp_err    = 1'b0;
    raster_idx = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) frm[r][c] = r * N + c;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) frm[r][c] = $urandom();
  endtask

  task automatic fill_const(input logic signed [DW-1:0] v);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) frm[r][c] = v;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_row   = '0;
    bus.in_col   = '0;
    bus.in_data  = '0;
    pend_v = 0; pend_fd = 0; pend_chk = 0; exp_err = 0; win_test = 0;
    pend_r = 0; pend_c = 0; pend_d = '0; raster_idx = 0;

    reset_pulse();

    // Ramp frame, back-to-back.
    fill_ramp();
    run_frame(0, -1, -1);

    // Random frame with a known first window (5,-3,9,2 -> 9).
    fill_rand();
    frm[0][0] = 5; frm[0][1] = -3; frm[1][0] = 9; frm[1][1] = 2;
    win_test = 1'b1;
    run_frame(0, -1, -1);
    drive(1'b0, 0, 0, 1'b1);
    win_test = 1'b0;

    // All-negative frame.
    fill_const(-100);
    run_frame(0, -1, -1);

    // Same random frame gapless, then with 0..5 idle cycles between inputs.
    fill_rand();
    run_frame(0, -1, -1);
    run_frame(5, -1, -1);

    // Reset in the middle of a ramp frame, after input (10,7), then a clean ramp frame.
    fill_ramp();
    run_frame(0, -1, 10 * N + 8);
    reset_pulse();
    run_frame(0, -1, -1);

    // Skip input (0,5): seq_err goes sticky across this and the next frame.
    fill_rand();
    run_frame(0, 5, -1);
    fill_ramp();
    run_frame(2, -1, -1);
    drive(1'b0, 0, 0, 1'b1);

    // Only reset clears seq_err.
    reset_pulse();
    drive(1'b0, 0, 0, 1'b1);
    drive(1'b0, 0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_maxpool_2x2.md
# conv_maxpool_2x2

Downstream of the second convolution adder: consumes the 28×28 stream of 32-bit conv2 results (valid, row, col, data) in raster order and emits a 14×14 stream of 2×2 stride-2 max-pooled values. Holds partial row maxima in a half-width line buffer and raises a one-cycle frame-done pulse alongside the final pooled output. It is the last compute stage before result storage.

## Interface
Parameters:
- DATA_W, 32, width of input/output samples (signed two's complement)
- IN_DIM, 28, input frame side length; must be even
- COORD_W, 5, width of input row/col; output coords are COORD_W-1 bits

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous and active-high
- in_valid  in  1  one-cycle qualifier per conv2 result (the adder's done)
- in_row  in  COORD_W  row of incoming sample, 0..IN_DIM-1
- in_col  in  COORD_W  column of incoming sample, 0..IN_DIM-1
- in_data  in  DATA_W  conv2 result
- out_valid  out  1  pooled sample valid
- out_row  out  COORD_W-1  pooled row, 0..IN_DIM/2-1
- out_col  out  COORD_W-1  pooled column, 0..IN_DIM/2-1
- out_data  out  DATA_W  pooled maximum
- frame_done  out  1  one-cycle pulse with last pooled output
- seq_err  out  1  sticky: input coordinate out of raster order

## Operation
- FSM states: IDLE, RUN.
- IDLE: accepts only in_valid with (0,0); anything else sets seq_err, is dropped. (0,0) moves to RUN; expected position advances.
- RUN: each in_valid compared to internal expected (row,col); mismatch sets seq_err; sample still processed using its own coordinates.
- Even col: sample stored in hold register h.
- Odd col, even row: line buffer entry [col>>1] ← max(h, in_data).
- Odd col, odd row: out_data ← max(lb[col>>1], h, in_data); out_row = row>>1, out_col = col>>1; out_valid pulses.
- Input (IN_DIM-1, IN_DIM-1): frame_done pulses with that output; FSM returns to IDLE, expected position reset to (0,0).
- Comparisons signed; equal values: either operand (identical result).
- No backpressure; upstream rate is arbitrary (gaps between in_valid allowed, h and line buffer hold indefinitely).
- seq_err cleared only by rst.

## Timing
- Reset values: out_valid 0, out_row 0, out_col 0, out_data 0, frame_done 0, seq_err 0, FSM IDLE, h 0, line buffer contents don't-care (never read before written within a frame).
- Latency: out_valid registered, asserted the cycle after the in_valid of the odd-row odd-col sample.
- Back-to-back in_valid every cycle supported; throughput one input per cycle, one output per 4 inputs max.
- seq_err asserted the cycle after the offending in_valid.
- Reset mid-frame: all outputs return to reset values immediately; next frame must restart at (0,0).
- New (0,0) while in RUN: seq_err set, FSM restarts frame from that sample.

## Configuration
- Macro MAXPOOL_RELU_EN.
- Defined: each in_data with sign bit set replaced by 0 before pooling (fused ReLU); out_data never negative.
- Undefined: raw signed values pooled; negative maxima passed through.

## Structure
- Shared package pool_pkg: DATA_W, IN_DIM, OUT_DIM = IN_DIM/2, COORD_W, FSM state enum, signed max function.
- One sub-module pool_line_buffer: OUT_DIM×DATA_W register array, one write port, one combinational read port indexed by col>>1.

## Test plan
- Ramp frame in_data = row*28+col, every cycle -> 196 outputs, out_data(r,c) = (2r+1)*28+2c+1; frame_done with out (13,13) = 783.
- Single window (0,0)=5,(0,1)=-3,(1,0)=9,(1,1)=2 -> out (0,0)=9, one cycle after (1,1).
- All-negative frame, -100 constant -> without MAXPOOL_RELU_EN out_data -100; with it 0.
- Random gaps of 0–5 idle cycles between inputs -> identical outputs to gapless run.
- Skip input (0,5) -> seq_err high from next cycle, stays high through frame and next frame until rst.
- Assert rst at input (10,7), then full frame -> outputs zero during reset, second frame matches ramp expectations, seq_err 0.
